// File: rtl/axis_splitter_tdest.sv
// AXIS packet demultiplexer: steers each packet to one of NUM_STREAMS outputs by its head-beat tdest.
// Out-of-range destinations are swallowed whole and tallied in a saturating drop counter.
module axis_splitter_tdest #(
    parameter int unsigned AXIS_BYTES     = 1,
    parameter int unsigned AXIS_USER_BITS = 1,
    parameter int unsigned TDEST_BITS     = 8,
    parameter int unsigned NUM_STREAMS    = 2
) (
    input  logic                                   clk,
    input  logic                                   sreset,
    input  logic [8*AXIS_BYTES-1:0]                axis_i_tdata,
    input  logic [AXIS_BYTES-1:0]                  axis_i_tkeep,
    input  logic [AXIS_USER_BITS-1:0]              axis_i_tuser,
    input  logic [TDEST_BITS-1:0]                  axis_i_tdest,
    input  logic                                   axis_i_tlast,
    input  logic                                   axis_i_tvalid,
    output logic                                   axis_i_tready,
    output logic [NUM_STREAMS*8*AXIS_BYTES-1:0]    axis_o_tdata,
    output logic [NUM_STREAMS*AXIS_BYTES-1:0]      axis_o_tkeep,
    output logic [NUM_STREAMS*AXIS_USER_BITS-1:0]  axis_o_tuser,
    output logic [NUM_STREAMS*TDEST_BITS-1:0]      axis_o_tdest,
    output logic [NUM_STREAMS-1:0]                 axis_o_tlast,
    output logic [NUM_STREAMS-1:0]                 axis_o_tvalid,
    input  logic [NUM_STREAMS-1:0]                 axis_o_tready,
    output logic [15:0]                            drop_count,
    output logic                                   busy
);

    localparam int unsigned DATA_W = 8 * AXIS_BYTES;
    localparam int unsigned SEL_W  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    // Wide enough for any tdest and for NUM_STREAMS up to 256
    localparam int unsigned CMP_W  = ((TDEST_BITS > 9) ? TDEST_BITS : 9) + 1;

    typedef enum logic [1:0] {
        ST_HEAD  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [SEL_W-1:0]                    r_sel;
    logic [SEL_W-1:0]                    w_sel_nxt;
    logic [SEL_W-1:0]                    w_tgt;
    logic [TDEST_BITS-1:0]               r_dest;
    logic [TDEST_BITS-1:0]               w_dest_nxt;
    logic [TDEST_BITS-1:0]               w_beat_dest;
    logic [15:0]                         r_drop_cnt;
    logic                                r_busy;
    logic                                w_in_range;
    logic                                w_tgt_stall;
    logic                                w_route;
    logic                                w_drop_done;

    logic [NUM_STREAMS-1:0]              r_valid;
    logic [NUM_STREAMS-1:0]              r_last;
    logic [NUM_STREAMS*DATA_W-1:0]       r_data;
    logic [NUM_STREAMS*AXIS_BYTES-1:0]   r_keep;
    logic [NUM_STREAMS*AXIS_USER_BITS-1:0] r_user;
    logic [NUM_STREAMS*TDEST_BITS-1:0]   r_odest;

    assign w_in_range = CMP_W'(axis_i_tdest) < CMP_W'(NUM_STREAMS);
    assign w_tgt      = (r_state == ST_HEAD) ? SEL_W'(axis_i_tdest) : r_sel;

    // Target slot is full and its consumer is not taking it this cycle
    always_comb begin
        w_tgt_stall = 1'b0;
        for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
            if (w_tgt == SEL_W'(k) && r_valid[k] && !axis_o_tready[k]) begin
                w_tgt_stall = 1'b1;
            end
        end
    end

    // Next-state, route/drop decisions and input ready
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_dest_nxt    = r_dest;
        w_beat_dest   = r_dest;
        w_route       = 1'b0;
        w_drop_done   = 1'b0;
        axis_i_tready = !w_tgt_stall;
        case (r_state)
            ST_HEAD: begin
                w_beat_dest = axis_i_tdest;
                if (!w_in_range) begin
                    axis_i_tready = 1'b1;
                    if (axis_i_tvalid) begin
                        if (axis_i_tlast) begin
                            w_drop_done = 1'b1;
                        end else begin
                            w_state_nxt = ST_DROP;
                        end
                    end
                end else if (axis_i_tvalid && !w_tgt_stall) begin
                    w_route    = 1'b1;
                    w_sel_nxt  = w_tgt;
                    w_dest_nxt = axis_i_tdest;
                    if (!axis_i_tlast) begin
                        w_state_nxt = ST_ROUTE;
                    end
                end
            end
            ST_ROUTE: begin
                if (axis_i_tvalid && !w_tgt_stall) begin
                    w_route = 1'b1;
                    if (axis_i_tlast) begin
                        w_state_nxt = ST_HEAD;
                    end
                end
            end
            ST_DROP: begin
                axis_i_tready = 1'b1;
                if (axis_i_tvalid && axis_i_tlast) begin
                    w_drop_done = 1'b1;
                    w_state_nxt = ST_HEAD;
                end
            end
            default: begin
                w_state_nxt = ST_HEAD;
            end
        endcase
    end

    // State, route selection and drop counter
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state    <= ST_HEAD;
            r_sel      <= '0;
            r_dest     <= '0;
            r_drop_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_dest  <= w_dest_nxt;
            r_busy  <= (w_state_nxt != ST_HEAD);
            if (w_drop_done && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Per-stream output slots; a new load takes priority over a drain
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_valid <= '0;
            r_last  <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_user  <= '0;
            r_odest <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
                if (w_route && w_tgt == SEL_W'(k)) begin
                    r_valid[k]                                  <= 1'b1;
                    r_last[k]                                   <= axis_i_tlast;
                    r_data[k*DATA_W +: DATA_W]                  <= axis_i_tdata;
                    r_keep[k*AXIS_BYTES +: AXIS_BYTES]          <= axis_i_tkeep;
                    r_user[k*AXIS_USER_BITS +: AXIS_USER_BITS]  <= axis_i_tuser;
                    r_odest[k*TDEST_BITS +: TDEST_BITS]         <= w_beat_dest;
                end else if (axis_o_tready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign axis_o_tvalid = r_valid;
    assign axis_o_tlast  = r_last;
    assign axis_o_tdata  = r_data;
    assign axis_o_tkeep  = r_keep;
    assign axis_o_tuser  = r_user;
    assign axis_o_tdest  = r_odest;
    assign drop_count    = r_drop_cnt;
    assign busy          = r_busy;

endmodule

// File: tb/tb_axis_splitter_tdest.sv
// Scoreboard bench for axis_splitter_tdest: packet-level routing model on the input side,
// per-stream expectation queues popped by a monitor whenever an output handshake occurs.
`timescale 1ns/1ps
module tb_axis_splitter_tdest;

    localparam int NS = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       user;
        logic [7:0] dest;
        logic       last;
    } beat_t;

    logic              clk = 1'b0;
    logic              sreset = 1'b1;
    logic [7:0]        axis_i_tdata = '0;
    logic [0:0]        axis_i_tkeep = '0;
    logic [0:0]        axis_i_tuser = '0;
    logic [7:0]        axis_i_tdest = '0;
    logic              axis_i_tlast = 1'b0;
    logic              axis_i_tvalid = 1'b0;
    logic              axis_i_tready;
    logic [NS*8-1:0]   axis_o_tdata;
    logic [NS-1:0]     axis_o_tkeep;
    logic [NS-1:0]     axis_o_tuser;
    logic [NS*8-1:0]   axis_o_tdest;
    logic [NS-1:0]     axis_o_tlast;
    logic [NS-1:0]     axis_o_tvalid;
    logic [NS-1:0]     axis_o_tready = '1;
    logic [15:0]       drop_count;
    logic              busy;

    int    n_vec = 0;
    int    n_err = 0;
    bit    rdy_random = 1'b0;
    logic [NS-1:0] rdy_fixed = '1;

    beat_t q [NS][$];
    bit    exp_busy = 1'b0;
    logic [15:0] exp_drop = '0;
    int    pkt_dest = 0;
    bit    pkt_drop = 1'b0;
    bit    hold [NS];
    beat_t held [NS];

    axis_splitter_tdest #(
        .AXIS_BYTES(1), .AXIS_USER_BITS(1), .TDEST_BITS(8), .NUM_STREAMS(NS)
    ) dut (
        .clk(clk), .sreset(sreset),
        .axis_i_tdata(axis_i_tdata), .axis_i_tkeep(axis_i_tkeep), .axis_i_tuser(axis_i_tuser),
        .axis_i_tdest(axis_i_tdest), .axis_i_tlast(axis_i_tlast), .axis_i_tvalid(axis_i_tvalid),
        .axis_i_tready(axis_i_tready),
        .axis_o_tdata(axis_o_tdata), .axis_o_tkeep(axis_o_tkeep), .axis_o_tuser(axis_o_tuser),
        .axis_o_tdest(axis_o_tdest), .axis_o_tlast(axis_o_tlast), .axis_o_tvalid(axis_o_tvalid),
        .axis_o_tready(axis_o_tready),
        .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic err(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    function automatic beat_t slot_beat(input int k);
        beat_t b;
        b.data = axis_o_tdata[k*8 +: 8];
        b.keep = axis_o_tkeep[k];
        b.user = axis_o_tuser[k];
        b.dest = axis_o_tdest[k*8 +: 8];
        b.last = axis_o_tlast[k];
        return b;
    endfunction

    // Output readiness, changed just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_random) begin
                for (int k = 0; k < NS; k++) axis_o_tready[k] = ($urandom_range(9) < 7);
            end else begin
                axis_o_tready = rdy_fixed;
            end
        end
    end

    // Monitor: input-side packet model feeds the queues; output handshakes pop and compare
    initial begin
        for (int k = 0; k < NS; k++) begin
            hold[k] = 1'b0;
            held[k] = '0;
        end
        forever begin
            @(negedge clk);
            if (sreset) begin
                for (int k = 0; k < NS; k++) begin
                    q[k].delete();
                    hold[k] = 1'b0;
                end
                exp_busy = 1'b0;
                exp_drop = '0;
                continue;
            end
            chk("busy", busy, exp_busy);
            chk("drop_count", drop_count, exp_drop);
            for (int k = 0; k < NS; k++) begin
                beat_t b;
                b = slot_beat(k);
                if (hold[k]) begin
                    chk($sformatf("s%0d_hold_valid", k), axis_o_tvalid[k], 1'b1);
                    chk($sformatf("s%0d_hold_payload", k), b, held[k]);
                end
                if (axis_o_tvalid[k] && axis_o_tready[k]) begin
                    if (q[k].size() == 0) begin
                        err($sformatf("s%0d_unexpected_beat data=0x%0h", k, b.data));
                    end else begin
                        chk($sformatf("s%0d_beat", k), b, q[k].pop_front());
                    end
                end
                hold[k] = axis_o_tvalid[k] && !axis_o_tready[k];
                held[k] = b;
            end
            if (axis_i_tvalid && axis_i_tready) begin
                if (!exp_busy) begin
                    pkt_dest = int'(axis_i_tdest);
                    pkt_drop = (pkt_dest >= NS);
                end
                if (!pkt_drop) begin
                    q[pkt_dest].push_back({axis_i_tdata, axis_i_tkeep, axis_i_tuser,
                                           8'(pkt_dest), axis_i_tlast});
                end
                if (axis_i_tlast) begin
                    exp_busy = 1'b0;
                    if (pkt_drop && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
                end else begin
                    exp_busy = 1'b1;
                end
            end
        end
    end

    // Present one beat and hold it until accepted; called just after a rising edge
    task automatic send_beat(input logic [7:0] d, input logic [7:0] dest, input logic last,
                             output int waited);
        axis_i_tdata  = d;
        axis_i_tkeep  = 1'($urandom);
        axis_i_tuser  = 1'($urandom);
        axis_i_tdest  = dest;
        axis_i_tlast  = last;
        axis_i_tvalid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (axis_i_tready) break;
            waited++;
            if (waited >= 200) begin
                err("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        axis_i_tvalid = 1'b0;
        axis_i_tdata  = 8'($urandom);
        axis_i_tdest  = 8'($urandom);
    endtask

    task automatic send_pkt(input logic [7:0] dest, input int len, input logic [7:0] base,
                            input bit scramble, input bit no_wait);
        int w;
        for (int i = 0; i < len; i++) begin
            logic [7:0] td;
            td = (i == 0 || !scramble) ? dest : 8'($urandom);
            send_beat(base + 8'(i), td, (i == len - 1), w);
            if (no_wait) chk($sformatf("no_stall_d%0d_b%0d", dest, i), w, 0);
        end
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 sreset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", axis_o_tvalid, '0);
        chk("rst_tlast", axis_o_tlast, '0);
        chk("rst_tdata", axis_o_tdata, '0);
        chk("rst_tkeep", axis_o_tkeep, '0);
        chk("rst_tuser", axis_o_tuser, '0);
        chk("rst_tdest", axis_o_tdest, '0);
        chk("rst_drop", drop_count, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tready", axis_i_tready, 1'b1);
        @(posedge clk);
        #1;

        // Basic routing and route lock
        send_pkt(8'd2, 4, 8'h10, 1'b0, 1'b1);
        send_pkt(8'd1, 4, 8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_beat(8'h30 + 8'(i), (i == 0) ? 8'd1 : 8'd0, (i == 3), w);
        end
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure on stream 0 while stream 1 drains a parked beat
        rdy_fixed = 3'b101;
        send_pkt(8'd1, 1, 8'h40, 1'b0, 1'b0);
        fork
            send_pkt(8'd0, 6, 8'h50, 1'b0, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 rdy_fixed[0] = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    if (c == 1) rdy_fixed[1] = 1'b1;
                    @(negedge clk);
                    if (c == 3) begin
                        chk("bp_tready_low", axis_i_tready, 1'b0);
                        chk("bp_s0_valid", axis_o_tvalid[0], 1'b1);
                        chk("bp_s1_drained", axis_o_tvalid[1], 1'b0);
                    end
                    @(posedge clk);
                    #1;
                end
                rdy_fixed[0] = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Drop, then an intact packet
        send_pkt(8'd7, 3, 8'h60, 1'b0, 1'b1);
        send_pkt(8'd0, 2, 8'h70, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_one", drop_count, 16'd1);
        @(posedge clk);
        #1;

        // Back-to-back single-beat packets
        send_pkt(8'd0, 1, 8'h80, 1'b0, 1'b1);
        send_pkt(8'd1, 1, 8'h81, 1'b0, 1'b1);
        send_pkt(8'd2, 1, 8'h82, 1'b0, 1'b1);
        send_pkt(8'd0, 1, 8'h83, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure
        rdy_random = 1'b1;
        for (int p = 0; p < 60; p++) begin
            logic [7:0] d;
            d = ($urandom_range(9) == 0) ? 8'hFF : 8'($urandom_range(4));
            send_pkt(d, $urandom_range(1, 5), 8'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_random = 1'b0;
        rdy_fixed  = '1;
        repeat (5) @(posedge clk);
        #1;

        // Reset in the middle of a packet
        send_beat(8'h90, 8'd1, 1'b0, w);
        send_beat(8'h91, 8'd1, 1'b0, w);
        sreset = 1'b1;
        @(posedge clk);
        #1 sreset = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", axis_o_tvalid, '0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        send_pkt(8'd0, 2, 8'hA0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Drop counter saturation
        axis_i_tdest  = 8'd200;
        axis_i_tlast  = 1'b1;
        axis_i_tvalid = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("sat_reach", drop_count, 16'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", drop_count, 16'hFFFF);
        @(posedge clk);
        #1 axis_i_tvalid = 1'b0;

        repeat (10) @(posedge clk);
        for (int k = 0; k < NS; k++) chk($sformatf("s%0d_leftover", k), q[k].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        err("global_timeout");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
